// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage request and forwarding/stall response bundle.
//   master: drives the ID instruction fields and flush, observes selects/stall.
//   slave : the hazard controller; consumes ID fields, drives selects, stall, stall_cnt.
interface fwd_hazard_ctrl_if;
    logic       id_valid;
    logic [1:0] id_ra;
    logic [1:0] id_rb;
    logic       id_uses_ra;
    logic       id_uses_rb;
    logic [1:0] id_rd;
    logic       id_we;
    logic       id_is_load;
    logic       flush;
    logic       fwd_a_s1;
    logic       fwd_a_s0;
    logic       fwd_b_s1;
    logic       fwd_b_s0;
    logic       stall;
    logic [7:0] stall_cnt;

    modport master (
        output id_valid, id_ra, id_rb, id_uses_ra, id_uses_rb, id_rd, id_we, id_is_load, flush,
        input  fwd_a_s1, fwd_a_s0, fwd_b_s1, fwd_b_s0, stall, stall_cnt
    );
    modport slave (
        input  id_valid, id_ra, id_rb, id_uses_ra, id_uses_rb, id_rd, id_we, id_is_load, flush,
        output fwd_a_s1, fwd_a_s0, fwd_b_s1, fwd_b_s0, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding select and load-use stall control for a 5-stage pipe.
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset
//   bus   : ID instruction fields + flush in; registered 4:1 mux selects,
//           combinational stall and saturating stall counter out
module fwd_hazard_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic       v;
        logic [1:0] rd;
        logic       we;
        logic       ld;
    } slot_t;

    slot_t      ex_q, mem_q, wb_q, ex_d;
    logic [1:0] fa_q, fa_d, fb_q, fb_d;
    logic [7:0] cnt_q, cnt_d;
    logic       accept;

    function automatic logic prod(input slot_t s, input logic [1:0] r);
        return s.v && s.we && (s.rd == r);
    endfunction

    // Nearest producer wins: EX (one ahead) before MEM before WB.
    function automatic logic [1:0] sel(input logic used, input logic [1:0] r,
                                       input slot_t e, input slot_t m, input slot_t w);
        return !used     ? 2'b00 :
               prod(e, r) ? 2'b01 :
               prod(m, r) ? 2'b10 :
               prod(w, r) ? 2'b11 : 2'b00;
    endfunction

    // Only a load sitting in EX stalls; a load in MEM is forwarded.
    assign bus.stall = bus.id_valid && !bus.flush && ex_q.v && ex_q.we && ex_q.ld &&
                       ((bus.id_uses_ra && ex_q.rd == bus.id_ra) ||
                        (bus.id_uses_rb && ex_q.rd == bus.id_rb));

    always_comb begin
        accept = bus.id_valid && !bus.stall && !bus.flush;
        ex_d   = accept ? slot_t'{1'b1, bus.id_rd, bus.id_we, bus.id_is_load} : slot_t'('0);
        fa_d   = accept ? sel(bus.id_uses_ra, bus.id_ra, ex_q, mem_q, wb_q) : 2'b00;
        fb_d   = accept ? sel(bus.id_uses_rb, bus.id_rb, ex_q, mem_q, wb_q) : 2'b00;
        cnt_d  = (bus.stall && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            fa_q  <= 2'b00;
            fb_q  <= 2'b00;
            cnt_q <= 8'h00;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            fa_q  <= fa_d;
            fb_q  <= fb_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.fwd_a_s1  = fa_q[1];
    assign bus.fwd_a_s0  = fa_q[0];
    assign bus.fwd_b_s1  = fb_q[1];
    assign bus.fwd_b_s0  = fb_q[0];
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed and randomized checks of fwd_hazard_ctrl against an issue-history model.
module tb_fwd_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fwd_hazard_ctrl_if bus();

    fwd_hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } ent_t;

    ent_t       hist[$];
    logic [1:0] m_fa, m_fb;
    int         m_cnt;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [1:0] fa, fb;

    assign fa = {bus.fwd_a_s1, bus.fwd_a_s0};
    assign fb = {bus.fwd_b_s1, bus.fwd_b_s0};

    function automatic void m_clear();
        ent_t b;
        b.v = 0; b.rd = 0; b.we = 0; b.ld = 0;
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(b);
        m_fa = 0; m_fb = 0; m_cnt = 0;
    endfunction

    function automatic bit m_stall();
        return bus.id_valid && !bus.flush && hist[0].v && hist[0].we && hist[0].ld &&
               ((bus.id_uses_ra && hist[0].rd == int'(bus.id_ra)) ||
                (bus.id_uses_rb && hist[0].rd == int'(bus.id_rb)));
    endfunction

    // hist[d] was issued d+1 cycles before the instruction in ID; select = distance.
    function automatic logic [1:0] m_sel(bit u, logic [1:0] r);
        if (!u) return 2'b00;
        for (int d = 0; d < 3; d++)
            if (hist[d].v && hist[d].we && hist[d].rd == int'(r)) return 2'(d + 1);
        return 2'b00;
    endfunction

    task automatic drive(input bit v, input logic [1:0] ra, input logic [1:0] rb,
                         input bit ua, input bit ub, input logic [1:0] rd,
                         input bit we, input bit ld, input bit fl);
        bus.id_valid = v; bus.id_ra = ra; bus.id_rb = rb;
        bus.id_uses_ra = ua; bus.id_uses_rb = ub; bus.id_rd = rd;
        bus.id_we = we; bus.id_is_load = ld; bus.flush = fl;
        #1;
    endtask

    task automatic tick();
        bit   st, acc;
        ent_t e;
        st  = m_stall();
        acc = bus.id_valid && !bus.flush && !st;
        m_fa = acc ? m_sel(bus.id_uses_ra, bus.id_ra) : 2'b00;
        m_fb = acc ? m_sel(bus.id_uses_rb, bus.id_rb) : 2'b00;
        if (st && m_cnt < 255) m_cnt++;
        e.v = acc; e.rd = acc ? int'(bus.id_rd) : 0; e.we = acc && bus.id_we; e.ld = acc && bus.id_is_load;
        hist.push_front(e);
        void'(hist.pop_back());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_clear();
        drive(1, 1, 1, 1, 1, 1, 1, 1, 0);
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        n_chk++; if (fa !== 2'b00 || fb !== 2'b00) begin n_fail++; $display("FAIL reset_fwd got=%b/%b exp=00/00", fa, fb); end
        n_chk++; if (bus.stall_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt got=%h exp=00", bus.stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
        tick();
        n_chk++; if (fa !== 2'b00 || fb !== 2'b00) begin n_fail++; $display("FAIL reset_first_instr got=%b/%b exp=00/00", fa, fb); end
    endtask

    task automatic test_alu_chain();
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL alu_chain_stall got=%b exp=0", bus.stall); end
        tick();
        n_chk++; if (fa !== 2'b01 || fb !== 2'b01) begin n_fail++; $display("FAIL alu_chain_fwd got=%b/%b exp=01/01", fa, fb); end
    endtask

    task automatic test_distance();
        logic [1:0] exp_sel[3];
        exp_sel[0] = 2'b10; exp_sel[1] = 2'b11; exp_sel[2] = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            do_reset();
            drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
            tick();
            for (int j = 0; j < k; j++) begin
                drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
                tick();
            end
            drive(1, 3, 0, 1, 0, 1, 1, 0, 0);
            tick();
            n_chk++; if (fa !== exp_sel[k-1]) begin n_fail++; $display("FAIL distance_%0d got=%b exp=%b", k + 1, fa, exp_sel[k-1]); end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
        tick();
        drive(1, 2, 1, 1, 0, 3, 1, 0, 0);
        n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall got=%b exp=1", bus.stall); end
        n_chk++; if (bus.stall_cnt !== 8'd0) begin n_fail++; $display("FAIL load_use_cnt0 got=%0d exp=0", bus.stall_cnt); end
        tick();
        n_chk++; if (bus.stall_cnt !== 8'd1) begin n_fail++; $display("FAIL load_use_cnt1 got=%0d exp=1", bus.stall_cnt); end
        n_chk++; if (fa !== 2'b00) begin n_fail++; $display("FAIL load_use_bubble got=%b exp=00", fa); end
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL load_use_one_cycle got=%b exp=0", bus.stall); end
        tick();
        n_chk++; if (fa !== 2'b10) begin n_fail++; $display("FAIL load_use_fwd got=%b exp=10", fa); end
        n_chk++; if (bus.stall_cnt !== 8'd1) begin n_fail++; $display("FAIL load_use_cnt_hold got=%0d exp=1", bus.stall_cnt); end
    endtask

    task automatic test_priority();
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        drive(1, 2, 1, 1, 1, 2, 1, 0, 0);
        tick();
        n_chk++; if (fb !== 2'b01 || fa !== 2'b00) begin n_fail++; $display("FAIL priority got=%b/%b exp=00/01", fa, fb); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
        tick();
        drive(1, 2, 2, 1, 1, 3, 1, 0, 1);
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", bus.stall); end
        tick();
        n_chk++; if (fa !== 2'b00 || fb !== 2'b00) begin n_fail++; $display("FAIL flush_fwd got=%b/%b exp=00/00", fa, fb); end
        n_chk++; if (bus.stall_cnt !== 8'd0) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=0", bus.stall_cnt); end
        drive(1, 3, 0, 1, 0, 1, 1, 0, 0);
        tick();
        n_chk++; if (fa !== 2'b00) begin n_fail++; $display("FAIL flush_bubble_no_prod got=%b exp=00", fa); end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        for (int i = 0; i < 620; i++) begin
            drive(1, 2, 0, 1, 0, 2, 1, 1, 0);
            tick();
        end
        n_chk++; if (bus.stall_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_cnt got=%h exp=ff", bus.stall_cnt); end
        if (!m_stall()) tick();
        n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall_pre got=%b exp=1", bus.stall); end
        tick();
        n_chk++; if (bus.stall_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_no_wrap got=%h exp=ff", bus.stall_cnt); end
        if (!m_stall()) tick();
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL midstall_reset_stall got=%b exp=0", bus.stall); end
        n_chk++; if (bus.stall_cnt !== 8'h00) begin n_fail++; $display("FAIL midstall_reset_cnt got=%h exp=00", bus.stall_cnt); end
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 2, 2, 1, 1, 1, 1, 0, 0);
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall got=%b exp=0", bus.stall); end
        tick();
        n_chk++; if (fa !== 2'b00 || fb !== 2'b00) begin n_fail++; $display("FAIL post_reset_fwd got=%b/%b exp=00/00", fa, fb); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 9) != 0, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            n_chk++; if (bus.stall !== m_stall()) begin n_fail++; $display("FAIL rand_stall i=%0d got=%b exp=%b", i, bus.stall, m_stall()); end
            tick();
            n_chk++; if (fa !== m_fa || fb !== m_fb) begin n_fail++; $display("FAIL rand_fwd i=%0d got=%b/%b exp=%b/%b", i, fa, fb, m_fa, m_fb); end
            n_chk++; if (bus.stall_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt i=%0d got=%0d exp=%0d", i, bus.stall_cnt, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_distance();
        test_load_use();
        test_priority();
        test_flush();
        test_saturation_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
